// File: rtl/stochastic_spike_encoder_pkg.sv
// Shared widths and refractory state encoding for the stochastic spike encoder.
package stochastic_spike_encoder_pkg;

  localparam int RAND_W    = 4;
  localparam int REFRACT_W = 3;
  localparam int WIN_W     = 4;
  localparam int CNT_W     = WIN_W + 1;

  typedef enum logic {
    ARMED   = 1'b0,
    REFRACT = 1'b1
  } ref_state_e;

endpackage

// File: rtl/stochastic_spike_encoder_window.sv
// Fixed-length window spike counter with a valid/ready output register and sticky overrun flag.
module spike_window_counter
  import stochastic_spike_encoder_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             fire_i,
  input  logic             count_ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             count_valid_o,
  output logic             overrun_o
);

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             win_end;
  logic             xfer;

  assign win_end = en_i && (win_cnt_q == '1);
  assign xfer    = valid_q && count_ready_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    win_cnt_d = win_cnt_q;
    acc_d     = acc_q;
    count_d   = count_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (en_i) begin
      win_cnt_d = win_cnt_q + WIN_W'(1);
    end

    if (xfer) begin
      valid_d = 1'b0;
    end

    // The closing window's count includes a fire in its last cycle.
    if (win_end) begin
      count_d   = acc_q + CNT_W'(fire_i);
      acc_d     = '0;
      valid_d   = 1'b1;
      overrun_d = overrun_q | (valid_q & ~count_ready_i);
    end else if (fire_i) begin
      acc_d = acc_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_cnt_q <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign count_o       = count_q;
  assign count_valid_o = valid_q;
  assign overrun_o     = overrun_q;

endmodule

// File: rtl/stochastic_spike_encoder.sv
// Bernoulli spike generator with programmable refractory period, feeding a windowed spike counter.
module stochastic_spike_encoder
  import stochastic_spike_encoder_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [RAND_W-1:0]    rand_i,
  input  logic [RAND_W-1:0]    prob_i,
  input  logic [REFRACT_W-1:0] refract_i,
  output logic                 spike_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 count_valid_o,
  input  logic                 count_ready_i,
  output logic                 overrun_o
);

  logic [REFRACT_W-1:0] ref_cnt_q, ref_cnt_d;
  ref_state_e           state;
  logic                 fire;
  logic                 spike_q;

  assign state = (ref_cnt_q == '0) ? ARMED : REFRACT;
  assign fire  = en_i && (state == ARMED) && (rand_i < prob_i);

  always_comb begin
    ref_cnt_d = ref_cnt_q;
    if (en_i) begin
      unique case (state)
        ARMED:   if (fire) ref_cnt_d = refract_i;
        REFRACT: ref_cnt_d = ref_cnt_q - REFRACT_W'(1);
        default: ref_cnt_d = ref_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ref_cnt_q <= '0;
      spike_q   <= 1'b0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      spike_q   <= fire;
    end
  end

  assign spike_o = spike_q;

  spike_window_counter u_window (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .fire_i        (fire),
    .count_ready_i (count_ready_i),
    .count_o       (count_o),
    .count_valid_o (count_valid_o),
    .overrun_o     (overrun_o)
  );

endmodule

// File: tb/tb_stochastic_spike_encoder.sv
// Self-checking bench: directed scenarios plus random traffic against an enabled-cycle-index model.
module tb_stochastic_spike_encoder;
  import stochastic_spike_encoder_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 en_i;
  logic [RAND_W-1:0]    rand_i;
  logic [RAND_W-1:0]    prob_i;
  logic [REFRACT_W-1:0] refract_i;
  logic                 spike_o;
  logic [CNT_W-1:0]     count_o;
  logic                 count_valid_o;
  logic                 count_ready_i;
  logic                 overrun_o;

  always #5 clk_i = ~clk_i;

  stochastic_spike_encoder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .rand_i        (rand_i),
    .prob_i        (prob_i),
    .refract_i     (refract_i),
    .spike_o       (spike_o),
    .count_o       (count_o),
    .count_valid_o (count_valid_o),
    .count_ready_i (count_ready_i),
    .overrun_o     (overrun_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counts enabled cycles since reset; a fire at index n forbids firing before n+1+refract.
  int m_n, m_next_ok, m_acc, m_count;
  bit m_valid, m_ovr, m_spike;
  int exp_count;
  bit exp_valid, exp_ovr, exp_spike;
  bit chk_en = 1'b0;

  task automatic model_reset();
    m_n = 0; m_next_ok = 0; m_acc = 0; m_count = 0;
    m_valid = 0; m_ovr = 0; m_spike = 0;
    exp_count = 0; exp_valid = 0; exp_ovr = 0; exp_spike = 0;
  endtask

  task automatic model_step();
    bit fire;
    fire = en_i && (m_n >= m_next_ok) && (int'(rand_i) < int'(prob_i));
    m_spike = fire;
    if (fire) m_next_ok = m_n + 1 + int'(refract_i);
    if (en_i && (m_n % 16 == 15)) begin
      if (m_valid && !count_ready_i) m_ovr = 1;
      m_count = m_acc + int'(fire);
      m_valid = 1;
      m_acc   = 0;
    end else begin
      if (fire) m_acc++;
      if (m_valid && count_ready_i) m_valid = 0;
    end
    if (en_i) m_n++;
  endtask

  task automatic step();
    model_step();
    @(posedge clk_i);
    #1;
    exp_spike = m_spike;
    exp_count = m_count;
    exp_valid = m_valid;
    exp_ovr   = m_ovr;
  endtask

  always @(negedge clk_i) begin
    if (chk_en && !rst_i) begin
      check("spike_o", 32'(spike_o), 32'(exp_spike));
      check("count_o", 32'(count_o), 32'(exp_count));
      check("count_valid_o", 32'(count_valid_o), 32'(exp_valid));
      check("overrun_o", 32'(overrun_o), 32'(exp_ovr));
    end
  end

  // Asynchronous assertion between edges; outputs must clear before the next edge.
  task automatic do_reset();
    rst_i = 1'b1;
    #2;
    check("rst spike_o", 32'(spike_o), 0);
    check("rst count_o", 32'(count_o), 0);
    check("rst count_valid_o", 32'(count_valid_o), 0);
    check("rst overrun_o", 32'(overrun_o), 0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic drive(input bit en, input int rnd, input int prob, input int refr, input bit rdy);
    en_i          = en;
    rand_i        = RAND_W'(rnd);
    prob_i        = RAND_W'(prob);
    refract_i     = REFRACT_W'(refr);
    count_ready_i = rdy;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk_en = 1'b1;

    // Reset mid-window with a pending count and ref_cnt=5.
    drive(1, 3, 15, 5, 0);
    for (int i = 0; i < 19; i++) step();
    check("pre-reset valid", 32'(count_valid_o), 1);
    do_reset();
    drive(1, 3, 0, 0, 0);
    for (int i = 0; i < 15; i++) step();
    check("window not yet done", 32'(count_valid_o), 0);
    step();
    check("window done after 16", 32'(count_valid_o), 1);
    check("empty window count", 32'(count_o), 0);

    // Always-fire.
    do_reset();
    drive(1, 3, 15, 0, 1);
    step();
    check("always-fire first spike", 32'(spike_o), 1);
    for (int i = 1; i < 16; i++) step();
    check("always-fire count", 32'(count_o), 16);
    check("always-fire valid", 32'(count_valid_o), 1);
    for (int i = 0; i < 16; i++) step();

    // Refractory of 3: one spike every 4th cycle.
    do_reset();
    drive(1, 3, 15, 3, 1);
    for (int i = 0; i < 16; i++) step();
    check("refract count", 32'(count_o), 4);

    // Never-fire sweep and the strict-compare boundary.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, i, 0, 0, 0);
      step();
    end
    check("never-fire count", 32'(count_o), 0);
    check("never-fire valid", 32'(count_valid_o), 1);
    drive(1, 5, 5, 0, 1);
    step();
    check("rand==prob no fire", 32'(spike_o), 0);
    drive(1, 4, 5, 0, 1);
    step();
    check("rand<prob fires", 32'(spike_o), 1);

    // Backpressure across two windows: 4 then 7.
    do_reset();
    drive(1, 3, 15, 3, 0);
    for (int i = 0; i < 16; i++) step();
    check("bp first count", 32'(count_o), 4);
    check("bp no overrun yet", 32'(overrun_o), 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, 3, (i < 13) ? 15 : 0, 1, 0);
      step();
    end
    check("bp second count", 32'(count_o), 7);
    check("bp overrun", 32'(overrun_o), 1);
    check("bp valid held", 32'(count_valid_o), 1);
    drive(1, 3, 0, 0, 1);
    step();
    check("bp valid drops", 32'(count_valid_o), 0);
    check("bp overrun sticky", 32'(overrun_o), 1);

    // Enable gating with refract=2: window spans 32 clocks, 6 spikes.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(i % 2 == 0, 3, 15, 2, 1);
      step();
    end
    check("gated window count", 32'(count_o), 6);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3, 0) != 0, $urandom_range(15, 0), $urandom_range(15, 0),
            $urandom_range(7, 0), $urandom_range(2, 0) == 0);
      step();
    end

    @(negedge clk_i);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
